// File: rtl/soc_system_onchip_mem_reader.sv
// Avalon-MM read master for the on-chip RAM: streams word_count words from base_addr
// out as one Avalon-ST packet through a small credit-managed FIFO.
module soc_system_onchip_mem_reader #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 64,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_clken,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_sop,
  output logic                src_eop
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINISH, FLUSH} state_t;

  state_t                  state;
  logic [ADDR_W:0]         issue_left;
  logic [ADDR_W:0]         out_idx;
  logic [ADDR_W:0]         last_idx;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [CW-1:0]           in_flight;
  logic [CW-1:0]           fifo_cnt;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [DATA_W-1:0]       mem [FIFO_DEPTH];
  logic                    push;
  logic                    pop;
  logic                    abort_ok;
  logic                    clear;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + CW'(vld_pipe[i]);
  end

  // Reads in flight hold a FIFO slot, so the FIFO can never overflow.
  assign avm_chipselect = (state == RUN) && (issue_left != '0) &&
                          (({1'b0, in_flight} + {1'b0, fifo_cnt}) < DEPTH_C);
  assign avm_write      = 1'b0;
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;

  assign abort_ok  = abort && (state == RUN || state == DRAIN);
  assign clear     = abort_ok || (state == FLUSH);
  assign push      = vld_pipe[READ_LATENCY-1] && (state == RUN || state == DRAIN);
  assign src_valid = (fifo_cnt != '0);
  assign pop       = src_valid && src_ready;
  assign src_data  = mem[rd_ptr];
  assign src_sop   = src_valid && (out_idx == '0);
  assign src_eop   = src_valid && (out_idx == last_idx);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      aborted     <= 1'b0;
      avm_address <= '0;
      issue_left  <= '0;
      out_idx     <= '0;
      last_idx    <= '0;
      vld_pipe    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;

      for (int i = READ_LATENCY - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
      vld_pipe[0] <= avm_chipselect;

      if (clear) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + PW'(1);
          out_idx <= out_idx + (ADDR_W+1)'(1);
        end
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end

      if (avm_chipselect) begin
        avm_address <= avm_address + ADDR_W'(1);
        issue_left  <= issue_left - (ADDR_W+1)'(1);
      end

      case (state)
        IDLE: if (start) begin
          avm_address <= base_addr;
          issue_left  <= word_count;
          last_idx    <= word_count - (ADDR_W+1)'(1);
          out_idx     <= '0;
          if (word_count == '0) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort_ok) state <= FLUSH;
          else if (avm_chipselect && issue_left == (ADDR_W+1)'(1)) state <= DRAIN;
        end
        DRAIN: begin
          if (abort_ok) state <= FLUSH;
          else if (pop && out_idx == last_idx) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: state <= IDLE;
        FLUSH: if (in_flight == '0) begin
          state   <= IDLE;
          aborted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_system_onchip_mem_reader.sv
// Directed bench: two readers (read latency 1 and 3) share stimulus; a per-instance
// monitor scoreboards addresses, stream order, sop/eop and credit.
module tb_soc_system_onchip_mem_reader;
  logic        clk = 1'b0;
  logic        reset, start, abort, src_ready;
  logic [12:0] base_addr;
  logic [13:0] word_count;

  logic [1:0]  cs_w, valid_w, sop_w, eop_w, busy_w, done_w, abt_w, we_w, ck_w;
  logic [12:0] addr_w [2];
  logic [63:0] data_w [2];
  logic [63:0] rdata_w [2];
  logic [7:0]  be_w [2];
  logic [63:0] rq0 [1];
  logic [63:0] rq1 [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [12:0] a);
    return {4{3'b000, a}};
  endfunction

  // RAM models: registered read, READ_LATENCY cycles from address to data
  always @(posedge clk) begin
    rq0[0] <= word(addr_w[0]);
    rq1[0] <= word(addr_w[1]);
    rq1[1] <= rq1[0];
    rq1[2] <= rq1[1];
  end
  assign rdata_w[0] = rq0[0];
  assign rdata_w[1] = rq1[2];

  soc_system_onchip_mem_reader #(.READ_LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .abort(abort), .busy(busy_w[0]), .done(done_w[0]), .aborted(abt_w[0]),
    .avm_address(addr_w[0]), .avm_chipselect(cs_w[0]), .avm_write(we_w[0]),
    .avm_byteenable(be_w[0]), .avm_clken(ck_w[0]), .avm_readdata(rdata_w[0]),
    .src_data(data_w[0]), .src_valid(valid_w[0]), .src_ready(src_ready),
    .src_sop(sop_w[0]), .src_eop(eop_w[0]));

  soc_system_onchip_mem_reader #(.READ_LATENCY(3)) u1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .abort(abort), .busy(busy_w[1]), .done(done_w[1]), .aborted(abt_w[1]),
    .avm_address(addr_w[1]), .avm_chipselect(cs_w[1]), .avm_write(we_w[1]),
    .avm_byteenable(be_w[1]), .avm_clken(ck_w[1]), .avm_readdata(rdata_w[1]),
    .src_data(data_w[1]), .src_valid(valid_w[1]), .src_ready(src_ready),
    .src_sop(sop_w[1]), .src_eop(eop_w[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound, input bit rnd);
    int n = 0;
    while (busy_w != 2'b00 && n < bound) begin
      if (rnd) src_ready = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    chk("idle_timeout", 64'(busy_w), 64'd0);
  endtask

  task automatic go(input logic [12:0] b, input logic [13:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, ".busy"},  64'(busy_w[k]),  64'd0);
      chk({tag, ".done"},  64'(done_w[k]),  64'd0);
      chk({tag, ".abt"},   64'(abt_w[k]),   64'd0);
      chk({tag, ".cs"},    64'(cs_w[k]),    64'd0);
      chk({tag, ".valid"}, 64'(valid_w[k]), 64'd0);
      chk({tag, ".sop"},   64'(sop_w[k]),   64'd0);
      chk({tag, ".eop"},   64'(eop_w[k]),   64'd0);
      chk({tag, ".addr"},  64'(addr_w[k]),  64'd0);
    end
  endtask

  // Scoreboard per instance
  int          m_beat [2];
  int          m_iss  [2];
  logic [12:0] m_base [2];
  logic [13:0] m_cnt  [2];
  bit          m_act  [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_act[k] = 1'b0;
      end else begin
        if (m_act[k] && cs_w[k]) begin
          chk($sformatf("u%0d.addr", k), 64'(addr_w[k]), 64'(13'(m_base[k] + 13'(m_iss[k]))));
          m_iss[k]++;
          chk($sformatf("u%0d.credit", k), 64'(m_iss[k] - m_beat[k] > 8), 64'd0);
        end
        if (m_act[k] && valid_w[k] && src_ready) begin
          chk($sformatf("u%0d.data", k), data_w[k], word(13'(m_base[k] + 13'(m_beat[k]))));
          chk($sformatf("u%0d.sop", k), 64'(sop_w[k]), 64'(m_beat[k] == 0));
          chk($sformatf("u%0d.eop", k), 64'(eop_w[k]), 64'(m_beat[k] == int'(m_cnt[k]) - 1));
          m_beat[k]++;
        end
        if (m_act[k] && done_w[k]) begin
          chk($sformatf("u%0d.beats", k), 64'(m_beat[k]), 64'(m_cnt[k]));
          m_act[k] = 1'b0;
        end
        if (abt_w[k]) m_act[k] = 1'b0;
        if (start && !busy_w[k]) begin
          m_base[k] = base_addr;
          m_cnt[k]  = word_count;
          m_beat[k] = 0;
          m_iss[k]  = 0;
          m_act[k]  = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [12:0] t3_addr [4];
    int n0, n1, pops;
    bit got_ab;
    t3_addr = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};

    reset = 1'b1; start = 1'b0; abort = 1'b0; src_ready = 1'b0;
    base_addr = '0; word_count = '0;
    repeat (3) cyc();
    chk_idle_outs("rst");
    chk("rst.we", 64'(we_w), 64'd0);
    chk("rst.clken", 64'(ck_w), 64'd3);
    chk("rst.be", 64'(be_w[0]), 64'hFF);
    reset = 1'b0;
    cyc();

    // 1: four words, cycle-exact timing on the latency-1 reader
    src_ready = 1'b1;
    go(13'h0010, 14'd4);
    for (int c = 1; c <= 8; c++) begin
      chk("t1.cs",    64'(cs_w[0]),    64'(c >= 1 && c <= 4));
      if (c <= 4) chk("t1.addr", 64'(addr_w[0]), 64'(13'h0010 + 13'(c - 1)));
      chk("t1.valid", 64'(valid_w[0]), 64'(c >= 3 && c <= 6));
      chk("t1.done",  64'(done_w[0]),  64'(c == 7));
      chk("t1.busy",  64'(busy_w[0]),  64'(c <= 7));
      if (c == 3) begin
        chk("t1.data0", data_w[0], 64'h0010_0010_0010_0010);
        chk("t1.sop0",  64'(sop_w[0]), 64'd1);
      end
      if (c == 6) begin
        chk("t1.data3", data_w[0], 64'h0013_0013_0013_0013);
        chk("t1.eop3",  64'(eop_w[0]), 64'd1);
      end
      cyc();
    end
    wait_idle(50, 1'b0);

    // 4: zero-length transfer
    go(13'h0123, 14'd0);
    chk("t4.cs",    64'(cs_w),    64'd0);
    chk("t4.valid", 64'(valid_w), 64'd0);
    chk("t4.done",  64'(done_w),  64'd3);
    chk("t4.busy",  64'(busy_w),  64'd3);
    cyc();
    chk("t4.done_end", 64'(done_w), 64'd0);
    chk("t4.busy_end", 64'(busy_w), 64'd0);

    // 3: address wrap
    go(13'h1FFE, 14'd4);
    for (int c = 0; c < 4; c++) begin
      chk("t3.cs",   64'(cs_w[0]),   64'd1);
      chk("t3.addr", 64'(addr_w[0]), 64'(t3_addr[c]));
      cyc();
    end
    chk("t3.cs_off", 64'(cs_w[0]), 64'd0);
    wait_idle(50, 1'b0);

    // 2: backpressure stops issue at FIFO_DEPTH
    src_ready = 1'b0;
    go(13'h0040, 14'd20);
    n0 = 0; n1 = 0;
    for (int c = 0; c < 12; c++) begin
      n0 += int'(cs_w[0]);
      n1 += int'(cs_w[1]);
      cyc();
    end
    chk("t2.issued0", 64'(n0), 64'd8);
    chk("t2.issued1", 64'(n1), 64'd8);
    chk("t2.cs_hold", 64'(cs_w), 64'd0);
    chk("t2.valid",   64'(valid_w), 64'd3);
    src_ready = 1'b1;
    wait_idle(200, 1'b0);

    // 5: abort mid-transfer
    go(13'h0200, 14'd16);
    pops = 0;
    for (int i = 0; i < 40 && pops < 5; i++) begin
      if (valid_w[0]) pops++;
      if (pops < 5) cyc();
    end
    chk("t5.beats", 64'(pops), 64'd5);
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5.valid_drop", 64'(valid_w[0]), 64'd0);
    chk("t5.busy_flush", 64'(busy_w[0]), 64'd1);
    got_ab = 1'b0;
    for (int i = 0; i < 10 && !got_ab; i++) begin
      chk("t5.flush_cs", 64'(cs_w[0]), 64'd0);
      if (abt_w[0]) begin
        got_ab = 1'b1;
        chk("t5.busy_abt", 64'(busy_w[0]), 64'd0);
      end else begin
        cyc();
      end
    end
    chk("t5.aborted", 64'(got_ab), 64'd1);
    cyc();
    chk("t5.abt_pulse", 64'(abt_w[0]), 64'd0);
    wait_idle(30, 1'b0);

    // abort while idle is ignored
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5.idle_abt_busy", 64'(busy_w), 64'd0);
    cyc();
    chk("t5.idle_abt_pulse", 64'(abt_w), 64'd0);

    // start and abort together in idle: start wins
    abort = 1'b1;
    go(13'h0300, 14'd3);
    abort = 1'b0;
    chk("t5.restart_busy", 64'(busy_w[0]), 64'd1);
    chk("t5.restart_cs",   64'(cs_w[0]),   64'd1);
    chk("t5.restart_addr", 64'(addr_w[0]), 64'h300);
    wait_idle(50, 1'b0);

    // full address space, wraps back to base
    go(13'h0005, 14'd8192);
    wait_idle(9000, 1'b0);

    // 6: random backpressure, then reset mid-transfer
    go(13'h1000, 14'd100);
    wait_idle(3000, 1'b1);
    go(13'h1F80, 14'd100);
    for (int i = 0; i < 60; i++) begin
      src_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("t6.mid_busy", 64'(busy_w), 64'd3);
    reset = 1'b1;
    cyc();
    chk_idle_outs("t6.rst");
    reset = 1'b0;
    src_ready = 1'b1;
    cyc();
    go(13'h0007, 14'd5);
    wait_idle(50, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
